// File: rtl/sram_access_ctrl.sv
// Memory-side controller for the single-port sRAM. Arbitrates between the
// instruction-fetch port (read only) and the load/store port, runs each access
// through a fixed IDLE -> ISSUE -> CAPTURE -> ACK sequence, and returns a
// registered one-cycle ack with read data and an illegal-address flag.
module sram_access_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MEM_DEPTH   = 8,
    parameter int LS_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_en,
    output logic              mem_rd,
    output logic              mem_wt,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    // Depth widened by one bit so a depth of 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_L = MEM_DEPTH[ADDR_W:0];

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              pick_ls;
    logic              last_ls;
    logic              gnt_ls;
    logic              we_lat;
    logic              err_lat;
    logic [ADDR_W-1:0] addr_lat;
    logic [DATA_W-1:0] wdata_lat;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_err;

    // Arbitration: fixed LS priority, or round-robin against the last grant.
    always_comb begin
        pick_ls = 1'b0;
        if (LS_PRIORITY != 0) begin
            pick_ls = ls_req;
        end else begin
            pick_ls = ls_req && (!if_req || !last_ls);
        end
        sel_addr = pick_ls ? ls_addr : if_addr;
        sel_err  = ({1'b0, sel_addr} >= DEPTH_L);
    end

    // Next-state logic and sRAM strobes, which are only ever live in ISSUE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mem_en    = 1'b0;
        mem_rd    = 1'b0;
        mem_wt    = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = ~err_lat;
                mem_wt    = we_lat & ~err_lat;
                mem_rd    = ~we_lat & ~err_lat;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = ACK;
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, loaded only on the accept edge so the sRAM address/data pins stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ls   <= 1'b0;
            gnt_ls    <= 1'b0;
            we_lat    <= 1'b0;
            err_lat   <= 1'b0;
            addr_lat  <= '0;
            wdata_lat <= '0;
        end else if (accept) begin
            last_ls   <= pick_ls;
            gnt_ls    <= pick_ls;
            we_lat    <= pick_ls & ls_we;
            err_lat   <= sel_err;
            addr_lat  <= sel_addr;
            wdata_lat <= pick_ls ? ls_wdata : '0;
        end
    end

    assign mem_add = addr_lat;
    assign mem_din = wdata_lat;

    // Response registers: ack/err raised leaving CAPTURE, cleared leaving ACK; rdata held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= '0;
            ls_ack   <= 1'b0;
            ls_err   <= 1'b0;
            ls_rdata <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (gnt_ls) begin
                        ls_ack <= 1'b1;
                        ls_err <= err_lat;
                        if (!we_lat) begin
                            ls_rdata <= err_lat ? '0 : mem_dout;
                        end
                    end else begin
                        if_ack   <= 1'b1;
                        if_err   <= err_lat;
                        if_rdata <= err_lat ? '0 : mem_dout;
                    end
                end
                ACK: begin
                    if_ack <= 1'b0;
                    if_err <= 1'b0;
                    ls_ack <= 1'b0;
                    ls_err <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
